dispatch_queue: RTL and testbench

- Buffered, parametrised dispatch stage between decoder and the ROB / reservation station / load-store queue of the Tomasulo core.
- Decoded instructions enter a QDEPTH-entry in-order FIFO. The FIFO head is dispatched once the ROB and the target unit both have room.
- On dispatch the block allocates the ROB entry, renames rd, and resolves both operands from regfile, ROB, or N_CDB result-bus bypass.
- It then presents one registered issue packet to RS or LSB; on flush it discards everything.

---
 rtl/dispatch_queue_pkg.sv | 44 ++++
 rtl/dispatch_queue_if.sv | 75 +++++++
 rtl/dispatch_operand_resolve.sv | 49 ++++
 rtl/dispatch_queue.sv | 155 +++++++++++++++
 tb/tb_dispatch_queue.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_queue_pkg.sv
// Shared widths, instruction-type codes and instruction-class helpers for the
// Tomasulo dispatch stage.
package dispatch_queue_pkg;

  localparam int DQ_XLEN   = 32;
  localparam int DQ_REG_W  = 5;
  localparam int DQ_ROB_W  = 4;
  localparam int DQ_TYPE_W = 6;

  typedef logic [DQ_TYPE_W-1:0] itype_t;

  // Branches, then loads and stores, are contiguous so class tests are range compares.
  localparam itype_t T_LUI   = 6'd1;
  localparam itype_t T_AUIPC = 6'd2;
  localparam itype_t T_JAL   = 6'd3;
  localparam itype_t T_JALR  = 6'd4;
  localparam itype_t T_BEQ   = 6'd5;
  localparam itype_t T_BGEU  = 6'd10;
  localparam itype_t T_LB    = 6'd11;
  localparam itype_t T_LW    = 6'd13;
  localparam itype_t T_SB    = 6'd16;
  localparam itype_t T_SW    = 6'd18;
  localparam itype_t T_ADDI  = 6'd19;
  localparam itype_t T_ADD   = 6'd28;

  localparam logic [DQ_ROB_W-1:0] NULL_TAG = '0;

  function automatic logic is_ls(input itype_t t);
    return (t >= T_LB) && (t <= T_SW);
  endfunction

  function automatic logic is_store(input itype_t t);
    return (t >= T_SB) && (t <= T_SW);
  endfunction

  function automatic logic is_branch(input itype_t t);
    return (t >= T_BEQ) && (t <= T_BGEU);
  endfunction

  function automatic logic writes_rd(input itype_t t);
    return !is_store(t) && !is_branch(t);
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Bundle of every non-clock signal between the dispatch stage and its
// neighbours (decoder, regfile, ROB, CDB, RS, LSB).
interface dispatch_queue_if #(
  parameter int XLEN   = 32,
  parameter int REG_W  = 5,
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 6,
  parameter int N_CDB  = 2
);
  logic                    rdy_in;
  logic                    flush_in;
  // Decoder handshake: a packet transfers on a rising clk edge where
  // dec_valid_in && dec_ready_out && rdy_in; the decoder holds fields stable
  // while dec_valid_in is high and not accepted.
  logic                    dec_valid_in;
  logic                    dec_ready_out;
  logic [TYPE_W-1:0]       dec_type_in;
  logic [REG_W-1:0]        dec_rs1_in, dec_rs2_in, dec_rd_in;
  logic [XLEN-1:0]         dec_imm_in, dec_pc_in;
  logic [REG_W-1:0]        reg_rs1_out, reg_rs2_out;
  logic [XLEN-1:0]         reg_rs1_data_in, reg_rs2_data_in;
  logic                    reg_rs1_busy_in, reg_rs2_busy_in;
  logic [ROB_W-1:0]        reg_rs1_tag_in, reg_rs2_tag_in;
  logic                    reg_rename_en_out;
  logic [REG_W-1:0]        reg_rename_rd_out;
  logic [ROB_W-1:0]        reg_rename_tag_out;
  logic                    rob_full_in;
  logic [ROB_W-1:0]        rob_idle_tag_in;
  logic                    rob_en_out;
  logic [TYPE_W-1:0]       rob_type_out;
  logic [XLEN-1:0]         rob_pc_out;
  logic [REG_W-1:0]        rob_rd_out;
  logic [ROB_W-1:0]        rob_q1_out, rob_q2_out;
  logic                    rob_q1_rdy_in, rob_q2_rdy_in;
  logic [XLEN-1:0]         rob_q1_data_in, rob_q2_data_in;
  logic [N_CDB-1:0]        cdb_valid_in;
  logic [N_CDB*ROB_W-1:0]  cdb_tag_in;
  logic [N_CDB*XLEN-1:0]   cdb_data_in;
  logic                    rs_full_in, lsb_full_in;
  logic                    rs_en_out, lsb_en_out;
  logic [XLEN-1:0]         iss_vj_out, iss_vk_out;
  logic                    iss_qj_busy_out, iss_qk_busy_out;
  logic [ROB_W-1:0]        iss_qj_out, iss_qk_out;
  logic [TYPE_W-1:0]       iss_type_out;
  logic [XLEN-1:0]         iss_imm_out, iss_pc_out;
  logic [ROB_W-1:0]        iss_dest_out;

  modport master (
    input  rdy_in, flush_in, dec_valid_in, dec_type_in, dec_rs1_in, dec_rs2_in,
           dec_rd_in, dec_imm_in, dec_pc_in, reg_rs1_data_in, reg_rs2_data_in,
           reg_rs1_busy_in, reg_rs2_busy_in, reg_rs1_tag_in, reg_rs2_tag_in,
           rob_full_in, rob_idle_tag_in, rob_q1_rdy_in, rob_q2_rdy_in,
           rob_q1_data_in, rob_q2_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in,
           rs_full_in, lsb_full_in,
    output dec_ready_out, reg_rs1_out, reg_rs2_out, reg_rename_en_out,
           reg_rename_rd_out, reg_rename_tag_out, rob_en_out, rob_type_out,
           rob_pc_out, rob_rd_out, rob_q1_out, rob_q2_out, rs_en_out, lsb_en_out,
           iss_vj_out, iss_vk_out, iss_qj_busy_out, iss_qk_busy_out, iss_qj_out,
           iss_qk_out, iss_type_out, iss_imm_out, iss_pc_out, iss_dest_out
  );

  modport slave (
    output rdy_in, flush_in, dec_valid_in, dec_type_in, dec_rs1_in, dec_rs2_in,
           dec_rd_in, dec_imm_in, dec_pc_in, reg_rs1_data_in, reg_rs2_data_in,
           reg_rs1_busy_in, reg_rs2_busy_in, reg_rs1_tag_in, reg_rs2_tag_in,
           rob_full_in, rob_idle_tag_in, rob_q1_rdy_in, rob_q2_rdy_in,
           rob_q1_data_in, rob_q2_data_in, cdb_valid_in, cdb_tag_in, cdb_data_in,
           rs_full_in, lsb_full_in,
    input  dec_ready_out, reg_rs1_out, reg_rs2_out, reg_rename_en_out,
           reg_rename_rd_out, reg_rename_tag_out, rob_en_out, rob_type_out,
           rob_pc_out, rob_rd_out, rob_q1_out, rob_q2_out, rs_en_out, lsb_en_out,
           iss_vj_out, iss_vk_out, iss_qj_busy_out, iss_qk_busy_out, iss_qj_out,
           iss_qk_out, iss_type_out, iss_imm_out, iss_pc_out, iss_dest_out
  );
endinterface

// File: rtl/dispatch_operand_resolve.sv
// Combinational single-source operand resolver: x0, regfile, ROB, then CDB
// bypass (lowest port wins); otherwise the operand waits on the regfile tag.
module dispatch_operand_resolve
  import dispatch_queue_pkg::*;
#(
  parameter int XLEN  = DQ_XLEN,
  parameter int REG_W = DQ_REG_W,
  parameter int ROB_W = DQ_ROB_W,
  parameter int N_CDB = 2
) (
  input  logic [REG_W-1:0]       rs,
  input  logic [XLEN-1:0]        reg_data,
  input  logic                   reg_busy,
  input  logic [ROB_W-1:0]       reg_tag,
  input  logic                   rob_rdy,
  input  logic [XLEN-1:0]        rob_data,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*ROB_W-1:0] cdb_tag,
  input  logic [N_CDB*XLEN-1:0]  cdb_data,
  output logic [XLEN-1:0]        val,
  output logic                   busy,
  output logic [ROB_W-1:0]       q
);

  always_comb begin
    val  = '0;
    busy = 1'b0;
    q    = ROB_W'(NULL_TAG);
    if (rs == '0) begin
      val = '0;
    end else if (!reg_busy) begin
      val = reg_data;
    end else if (rob_rdy) begin
      val = rob_data;
    end else begin
      busy = 1'b1;
      q    = reg_tag;
      // Scan high to low so the lowest matching port is the one left standing.
      for (int i = N_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && (cdb_tag[i*ROB_W +: ROB_W] == reg_tag)) begin
          val  = cdb_data[i*XLEN +: XLEN];
          busy = 1'b0;
          q    = ROB_W'(NULL_TAG);
        end
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO: pops the head into ROB + rename when the ROB and the
// target RS/LSB have room, and registers a resolved issue packet.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int XLEN   = DQ_XLEN,
  parameter int REG_W  = DQ_REG_W,
  parameter int ROB_W  = DQ_ROB_W,
  parameter int TYPE_W = DQ_TYPE_W,
  parameter int QDEPTH = 4,
  parameter int N_CDB  = 2
) (
  input logic             clk_in,
  input logic             rst_in,
  dispatch_queue_if.master bus
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);

  logic [TYPE_W-1:0] type_q [QDEPTH];
  logic [REG_W-1:0]  rs1_q  [QDEPTH];
  logic [REG_W-1:0]  rs2_q  [QDEPTH];
  logic [REG_W-1:0]  rd_q   [QDEPTH];
  logic [XLEN-1:0]   imm_q  [QDEPTH];
  logic [XLEN-1:0]   pc_q   [QDEPTH];
  logic              ls_q   [QDEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic             enq, issue_fire, head_ls;

  logic [XLEN-1:0]  vj, vk;
  logic             qj_busy, qk_busy;
  logic [ROB_W-1:0] qj, qk;

  logic             rs_en, lsb_en;
  logic [XLEN-1:0]  iss_vj, iss_vk, iss_imm, iss_pc;
  logic             iss_qj_busy, iss_qk_busy;
  logic [ROB_W-1:0] iss_qj, iss_qk, iss_dest;
  logic [TYPE_W-1:0] iss_type;

  assign head_ls = ls_q[head];
  assign bus.dec_ready_out = (count < FULL_CNT);
  assign enq = bus.rdy_in && !bus.flush_in && bus.dec_valid_in && bus.dec_ready_out;
  assign issue_fire = bus.rdy_in && !bus.flush_in && (count != '0) && !bus.rob_full_in &&
                      !(head_ls ? bus.lsb_full_in : bus.rs_full_in);

  assign bus.reg_rs1_out        = rs1_q[head];
  assign bus.reg_rs2_out        = rs2_q[head];
  assign bus.rob_en_out         = issue_fire;
  assign bus.rob_type_out       = type_q[head];
  assign bus.rob_pc_out         = pc_q[head];
  assign bus.rob_rd_out         = rd_q[head];
  assign bus.rob_q1_out         = bus.reg_rs1_tag_in;
  assign bus.rob_q2_out         = bus.reg_rs2_tag_in;
  assign bus.reg_rename_en_out  = issue_fire && (rd_q[head] != '0) && writes_rd(type_q[head]);
  assign bus.reg_rename_rd_out  = rd_q[head];
  assign bus.reg_rename_tag_out = bus.rob_idle_tag_in;

  dispatch_operand_resolve #(.XLEN(XLEN), .REG_W(REG_W), .ROB_W(ROB_W), .N_CDB(N_CDB)) u_rs1 (
    .rs(rs1_q[head]), .reg_data(bus.reg_rs1_data_in), .reg_busy(bus.reg_rs1_busy_in),
    .reg_tag(bus.reg_rs1_tag_in), .rob_rdy(bus.rob_q1_rdy_in), .rob_data(bus.rob_q1_data_in),
    .cdb_valid(bus.cdb_valid_in), .cdb_tag(bus.cdb_tag_in), .cdb_data(bus.cdb_data_in),
    .val(vj), .busy(qj_busy), .q(qj)
  );

  dispatch_operand_resolve #(.XLEN(XLEN), .REG_W(REG_W), .ROB_W(ROB_W), .N_CDB(N_CDB)) u_rs2 (
    .rs(rs2_q[head]), .reg_data(bus.reg_rs2_data_in), .reg_busy(bus.reg_rs2_busy_in),
    .reg_tag(bus.reg_rs2_tag_in), .rob_rdy(bus.rob_q2_rdy_in), .rob_data(bus.rob_q2_data_in),
    .cdb_valid(bus.cdb_valid_in), .cdb_tag(bus.cdb_tag_in), .cdb_data(bus.cdb_data_in),
    .val(vk), .busy(qk_busy), .q(qk)
  );

  // Entry payload needs no reset: count gates every read of it.
  always_ff @(posedge clk_in) begin
    if (enq) begin
      type_q[tail] <= bus.dec_type_in;
      rs1_q[tail]  <= bus.dec_rs1_in;
      rs2_q[tail]  <= bus.dec_rs2_in;
      rd_q[tail]   <= bus.dec_rd_in;
      imm_q[tail]  <= bus.dec_imm_in;
      pc_q[tail]   <= bus.dec_pc_in;
      ls_q[tail]   <= is_ls(bus.dec_type_in);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq)        tail <= tail + 1'b1;
        if (issue_fire) head <= head + 1'b1;
        case ({enq, issue_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rs_en       <= 1'b0;
      lsb_en      <= 1'b0;
      iss_vj      <= '0;
      iss_vk      <= '0;
      iss_qj_busy <= 1'b0;
      iss_qk_busy <= 1'b0;
      iss_qj      <= '0;
      iss_qk      <= '0;
      iss_type    <= '0;
      iss_imm     <= '0;
      iss_pc      <= '0;
      iss_dest    <= '0;
    end else if (bus.rdy_in) begin
      rs_en  <= issue_fire && !head_ls;
      lsb_en <= issue_fire && head_ls;
      if (issue_fire) begin
        iss_vj      <= vj;
        iss_vk      <= vk;
        iss_qj_busy <= qj_busy;
        iss_qk_busy <= qk_busy;
        iss_qj      <= qj;
        iss_qk      <= qk;
        iss_type    <= type_q[head];
        iss_imm     <= imm_q[head];
        iss_pc      <= pc_q[head];
        iss_dest    <= bus.rob_idle_tag_in;
      end
    end
  end

  assign bus.rs_en_out       = rs_en;
  assign bus.lsb_en_out      = lsb_en;
  assign bus.iss_vj_out      = iss_vj;
  assign bus.iss_vk_out      = iss_vk;
  assign bus.iss_qj_busy_out = iss_qj_busy;
  assign bus.iss_qk_busy_out = iss_qk_busy;
  assign bus.iss_qj_out      = iss_qj;
  assign bus.iss_qk_out      = iss_qk;
  assign bus.iss_type_out    = iss_type;
  assign bus.iss_imm_out     = iss_imm;
  assign bus.iss_pc_out      = iss_pc;
  assign bus.iss_dest_out    = iss_dest;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: reset, rename/dependency, bypass priority,
// back-pressure, store/x0 rename rules, freeze, flush and mid-traffic reset.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dispatch_queue_if bus ();
  dispatch_queue dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.rdy_in = 1'b1;           bus.flush_in = 1'b0;
    bus.dec_valid_in = 1'b0;     bus.dec_type_in = '0;
    bus.dec_rs1_in = '0;         bus.dec_rs2_in = '0;        bus.dec_rd_in = '0;
    bus.dec_imm_in = '0;         bus.dec_pc_in = '0;
    bus.reg_rs1_data_in = '0;    bus.reg_rs2_data_in = '0;
    bus.reg_rs1_busy_in = 1'b0;  bus.reg_rs2_busy_in = 1'b0;
    bus.reg_rs1_tag_in = '0;     bus.reg_rs2_tag_in = '0;
    bus.rob_full_in = 1'b0;      bus.rob_idle_tag_in = '0;
    bus.rob_q1_rdy_in = 1'b0;    bus.rob_q2_rdy_in = 1'b0;
    bus.rob_q1_data_in = '0;     bus.rob_q2_data_in = '0;
    bus.cdb_valid_in = '0;       bus.cdb_tag_in = '0;        bus.cdb_data_in = '0;
    bus.rs_full_in = 1'b0;       bus.lsb_full_in = 1'b0;
  endtask

  task automatic set_dec(input logic [5:0] t, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
    bus.dec_valid_in = 1'b1;
    bus.dec_type_in  = t;
    bus.dec_rs1_in   = rs1;
    bus.dec_rs2_in   = rs2;
    bus.dec_rd_in    = rd;
    bus.dec_imm_in   = imm;
    bus.dec_pc_in    = pc;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_dec_ready", bus.dec_ready_out, 1);
    check("rst_rs_en", bus.rs_en_out, 0);
    check("rst_lsb_en", bus.lsb_en_out, 0);
    check("rst_rob_en", bus.rob_en_out, 0);
    check("rst_iss_pc", bus.iss_pc_out, 0);
    rst_in = 1'b1;
    tick();

    // ADDI x1,x0,5 then ADD x2,x1,x1 with ROB tags 3 and 4
    set_dec(T_ADDI, 5'd0, 5'd0, 5'd1, 32'd5, 32'h1000);
    tick();
    set_dec(T_ADD, 5'd1, 5'd1, 5'd2, 32'd0, 32'h1004);
    bus.rob_idle_tag_in = 4'd3;
    #1;
    check("a_rob_en", bus.rob_en_out, 1);
    check("a_rename_en", bus.reg_rename_en_out, 1);
    check("a_rename_rd", bus.reg_rename_rd_out, 1);
    check("a_rename_tag", bus.reg_rename_tag_out, 3);
    check("a_rob_pc", bus.rob_pc_out, 32'h1000);
    tick();
    bus.dec_valid_in = 1'b0;
    check("a_rs_en", bus.rs_en_out, 1);
    check("a_dest", bus.iss_dest_out, 3);
    check("a_imm", bus.iss_imm_out, 5);
    check("a_vj", bus.iss_vj_out, 0);
    check("a_qj_busy", bus.iss_qj_busy_out, 0);
    bus.rob_idle_tag_in = 4'd4;
    bus.reg_rs1_busy_in = 1'b1;  bus.reg_rs1_tag_in = 4'd3;
    bus.reg_rs2_busy_in = 1'b1;  bus.reg_rs2_tag_in = 4'd3;
    #1;
    check("a2_reg_rs1", bus.reg_rs1_out, 1);
    check("a2_rename_rd", bus.reg_rename_rd_out, 2);
    check("a2_rename_tag", bus.reg_rename_tag_out, 4);
    check("a2_rob_q1", bus.rob_q1_out, 3);
    tick();
    check("a2_rs_en", bus.rs_en_out, 1);
    check("a2_qj", bus.iss_qj_out, 3);
    check("a2_qk", bus.iss_qk_out, 3);
    check("a2_qj_busy", bus.iss_qj_busy_out, 1);
    check("a2_qk_busy", bus.iss_qk_busy_out, 1);
    check("a2_dest", bus.iss_dest_out, 4);
    check("a2_pc", bus.iss_pc_out, 32'h1004);
    tick();
    check("a_rs_en_clear", bus.rs_en_out, 0);

    // CDB bypass: only port 1 valid, then both ports tag 5
    idle();
    set_dec(T_ADD, 5'd5, 5'd6, 5'd7, 32'd0, 32'h2000);
    tick();
    bus.dec_valid_in = 1'b0;
    bus.reg_rs1_busy_in = 1'b1;  bus.reg_rs1_tag_in = 4'd5;
    bus.reg_rs2_data_in = 32'h0000AAAA;
    bus.cdb_valid_in = 2'b10;
    bus.cdb_tag_in = {4'd5, 4'd5};
    bus.cdb_data_in = {32'hDEADBEEF, 32'h11111111};
    bus.rob_idle_tag_in = 4'd9;
    tick();
    check("b_vj_port1", bus.iss_vj_out, 32'hDEADBEEF);
    check("b_qj_busy", bus.iss_qj_busy_out, 0);
    check("b_qj_null", bus.iss_qj_out, 0);
    check("b_vk_reg", bus.iss_vk_out, 32'h0000AAAA);
    set_dec(T_ADD, 5'd5, 5'd6, 5'd7, 32'd0, 32'h2004);
    tick();
    bus.dec_valid_in = 1'b0;
    bus.cdb_valid_in = 2'b11;
    bus.cdb_data_in = {32'hDEADBEEF, 32'h12345678};
    bus.reg_rs2_busy_in = 1'b1;  bus.reg_rs2_tag_in = 4'd6;
    bus.rob_q2_rdy_in = 1'b1;    bus.rob_q2_data_in = 32'h0000BBBB;
    tick();
    check("b2_vj_port0", bus.iss_vj_out, 32'h12345678);
    check("b2_vk_rob", bus.iss_vk_out, 32'h0000BBBB);
    check("b2_qk_busy", bus.iss_qk_busy_out, 0);
    set_dec(T_ADD, 5'd5, 5'd0, 5'd7, 32'd0, 32'h2008);
    tick();
    bus.dec_valid_in = 1'b0;
    bus.reg_rs1_busy_in = 1'b0;  bus.reg_rs1_data_in = 32'h77;
    bus.rob_q1_rdy_in = 1'b1;    bus.rob_q1_data_in = 32'h99;
    tick();
    check("b3_vj_reg_first", bus.iss_vj_out, 32'h77);
    check("b3_vk_x0", bus.iss_vk_out, 0);

    // Back-pressure: 4 accepted, 5th refused, then 4 consecutive issues
    idle();
    bus.rs_full_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("c_ready_%0d", k), bus.dec_ready_out, 1);
      set_dec(T_ADDI, 5'd1, 5'd0, 5'd3, 32'(k), 32'h3000 + 32'(4 * k));
      tick();
    end
    check("c_full_ready", bus.dec_ready_out, 0);
    check("c_blocked_rob_en", bus.rob_en_out, 0);
    set_dec(T_ADDI, 5'd1, 5'd0, 5'd3, 32'd4, 32'h3010);
    tick();
    bus.dec_valid_in = 1'b0;
    bus.rs_full_in = 1'b0;
    #1;
    check("c_rob_en", bus.rob_en_out, 1);
    check("c_head_pc", bus.rob_pc_out, 32'h3000);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("c_rs_en_%0d", k), bus.rs_en_out, 1);
      check($sformatf("c_pc_%0d", k), bus.iss_pc_out, 32'h3000 + 32'(4 * k));
    end
    check("c_empty_rob_en", bus.rob_en_out, 0);
    tick();
    check("c_rs_en_clear", bus.rs_en_out, 0);

    // Store goes to LSB without rename; ADD to x0 allocates ROB but no rename
    idle();
    set_dec(T_SW, 5'd2, 5'd3, 5'd5, 32'd0, 32'h4000);
    tick();
    set_dec(T_ADD, 5'd1, 5'd1, 5'd4, 32'd0, 32'h4004);
    #1;
    check("d_sw_rob_en", bus.rob_en_out, 1);
    check("d_sw_rename", bus.reg_rename_en_out, 0);
    tick();
    check("d_sw_lsb_en", bus.lsb_en_out, 1);
    check("d_sw_rs_en", bus.rs_en_out, 0);
    set_dec(T_ADD, 5'd1, 5'd1, 5'd0, 32'd0, 32'h4008);
    #1;
    check("d_add_rename", bus.reg_rename_en_out, 1);
    check("d_add_rename_rd", bus.reg_rename_rd_out, 4);
    tick();
    check("d_add_rs_en", bus.rs_en_out, 1);
    check("d_add_lsb_en", bus.lsb_en_out, 0);
    bus.dec_valid_in = 1'b0;
    #1;
    check("d_x0_rob_en", bus.rob_en_out, 1);
    check("d_x0_rename", bus.reg_rename_en_out, 0);
    tick();
    check("d_x0_rs_en", bus.rs_en_out, 1);

    // rdy_in low freezes queue and issue register
    idle();
    bus.rs_full_in = 1'b1;
    set_dec(T_ADDI, 5'd1, 5'd0, 5'd1, 32'd0, 32'h6000);
    tick();
    bus.rdy_in = 1'b0;
    bus.rs_full_in = 1'b0;
    set_dec(T_ADDI, 5'd1, 5'd0, 5'd1, 32'd0, 32'h6004);
    #1;
    check("f_frozen_rob_en", bus.rob_en_out, 0);
    check("f_frozen_rename", bus.reg_rename_en_out, 0);
    tick();
    tick();
    check("f_frozen_rs_en", bus.rs_en_out, 0);
    bus.rdy_in = 1'b1;
    bus.dec_valid_in = 1'b0;
    #1;
    check("f_rob_en", bus.rob_en_out, 1);
    check("f_head_pc", bus.rob_pc_out, 32'h6000);
    tick();
    check("f_rs_en", bus.rs_en_out, 1);
    check("f_no_extra", bus.rob_en_out, 0);
    bus.rdy_in = 1'b0;
    tick();
    check("f_rs_en_held", bus.rs_en_out, 1);
    bus.rdy_in = 1'b1;
    tick();
    check("f_rs_en_clear", bus.rs_en_out, 0);

    // Flush a full queue right after one issue fired
    idle();
    bus.rs_full_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_dec(T_ADDI, 5'd1, 5'd0, 5'd1, 32'd0, 32'h5000 + 32'(4 * k));
      tick();
    end
    bus.dec_valid_in = 1'b0;
    check("e_full_ready", bus.dec_ready_out, 0);
    bus.rs_full_in = 1'b0;
    tick();
    check("e_pre_rs_en", bus.rs_en_out, 1);
    bus.flush_in = 1'b1;
    #1;
    check("e_flush_rob_en", bus.rob_en_out, 0);
    check("e_flush_rename", bus.reg_rename_en_out, 0);
    tick();
    bus.flush_in = 1'b0;
    #1;
    check("e_rs_en", bus.rs_en_out, 0);
    check("e_lsb_en", bus.lsb_en_out, 0);
    check("e_ready", bus.dec_ready_out, 1);
    check("e_empty_rob_en", bus.rob_en_out, 0);

    // Asynchronous reset with 3 entries queued
    idle();
    bus.rs_full_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_dec(T_ADDI, 5'd1, 5'd0, 5'd1, 32'd0, 32'h7000 + 32'(4 * k));
      tick();
    end
    bus.dec_valid_in = 1'b0;
    bus.rs_full_in = 1'b0;
    #1;
    check("g_pre_rob_en", bus.rob_en_out, 1);
    rst_in = 1'b0;
    #1;
    check("g_rob_en", bus.rob_en_out, 0);
    check("g_rename_en", bus.reg_rename_en_out, 0);
    check("g_rs_en", bus.rs_en_out, 0);
    check("g_ready", bus.dec_ready_out, 1);
    check("g_iss_pc", bus.iss_pc_out, 0);
    tick();
    rst_in = 1'b1;
    #1;
    check("g_post_rob_en", bus.rob_en_out, 0);
    tick();
    check("g_post_rs_en", bus.rs_en_out, 0);
    check("g_post_ready", bus.dec_ready_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
